// File: rtl/stack_ctrl_if.sv
// Request/response channel between the control unit and stack_ctrl.
//   req_valid/req_ready : request handshake (transfer when both are 1)
//   req_op              : 00 push, 01 pop, 10 peek, 11 clear
//   req_data            : push data
//   rsp_valid           : one-cycle response strobe, no backpressure
//   rsp_err             : request rejected (overflow/underflow)
//   rsp_data            : popped/peeked word, 0 for push/clear/error
// master = control unit side, slave = stack_ctrl side.
interface stack_ctrl_if #(
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_err, rsp_data
  );
endinterface

// File: rtl/stack_ctrl.sv
// LIFO stack sequencer. Owns the stack pointer and turns single
// push/pop/peek/clear requests into accesses on a single-port synchronous RAM.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   bus (slave)     : request/response channel (see stack_ctrl_if)
//   mem_en/mem_we   : RAM enable / write enable (forced 0 during reset)
//   mem_addr        : RAM address
//   mem_wdata       : RAM write data
//   mem_rdata       : RAM read data, valid the cycle after a read
//   sp              : entry count 0..DEPTH
//   full/empty      : sp==DEPTH / sp==0
module stack_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  stack_ctrl_if.slave       bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   sp,
  output logic              full,
  output logic              empty
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, RWAIT, CLR, ERR, RSP
  } state_e;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_PEEK  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  state_e            state, state_next;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              accept;

  assign full   = (sp == (ADDR_W+1)'(DEPTH));
  assign empty  = (sp == '0);
  assign accept = bus.req_valid && (state == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          case (op_e'(bus.req_op))
            OP_PUSH:  state_next = full  ? ERR : WR;
            OP_POP,
            OP_PEEK:  state_next = empty ? ERR : RD;
            default:  state_next = CLR;
          endcase
        end
      end
      WR:      state_next = RSP;
      RD:      state_next = RWAIT;
      RWAIT:   state_next = RSP;
      CLR:     state_next = RSP;
      ERR:     state_next = IDLE;
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RSP) || (state == ERR);
    bus.rsp_err   = (state == ERR);
    bus.rsp_data  = rsp_data_q;
    mem_en        = !reset && ((state == WR) || (state == RD));
    mem_we        = !reset && (state == WR);
    // RD targets the top entry sp-1; the low bits wrap correctly even at sp==DEPTH.
    mem_addr      = (state == RD) ? (sp[ADDR_W-1:0] - ADDR_W'(1)) : sp[ADDR_W-1:0];
    mem_wdata     = data_q;
  end

  // Datapath: stack pointer, latched request, response data
  always_ff @(posedge clk) begin
    if (reset) begin
      sp         <= '0;
      op_q       <= OP_PUSH;
      data_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= op_e'(bus.req_op);
            data_q <= bus.req_data;
            // Error response appears next cycle, so its zero data is loaded now.
            if (state_next == ERR) rsp_data_q <= '0;
          end
        end
        WR: begin
          sp         <= sp + 1'b1;
          rsp_data_q <= '0;
        end
        RWAIT: begin
          rsp_data_q <= mem_rdata;
          if (op_q == OP_POP) sp <= sp - 1'b1;
        end
        CLR: begin
          sp         <= '0;
          rsp_data_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl with a behavioural
// single-port synchronous RAM attached.
module tb_stack_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [ADDR_W:0]   sp;
  logic              full, empty;

  stack_ctrl_if #(.DATA_W(DATA_W)) bus ();

  stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .sp        (sp),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // RAM model plus access monitor
  logic [DATA_W-1:0] ram [DEPTH];
  int                acc_cnt = 0;
  int                wr_cnt  = 0;
  logic [ADDR_W-1:0] last_waddr = '0;
  logic [DATA_W-1:0] last_wdata = '0;

  always @(posedge clk) begin
    if (mem_en) begin
      acc_cnt <= acc_cnt + 1;
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wr_cnt        <= wr_cnt + 1;
        last_waddr    <= mem_addr;
        last_wdata    <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called and returns at a falling edge. Latency counts cycles after the
  // acceptance edge until rsp_valid is seen.
  task automatic do_req(input logic [1:0] op, input logic [DATA_W-1:0] d,
                        input int lat, input logic err, input logic [DATA_W-1:0] exp_d,
                        input string tag);
    int n;
    check_eq({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs to confirm the request was latched.
    bus.req_valid = 1'b0;
    bus.req_op    = ~op;
    bus.req_data  = 32'hDEADBEEF;
    n = 1;
    while (!bus.rsp_valid && n < 6) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    if (bus.rsp_valid) begin
      check_eq({tag, "_latency"}, 64'(n), 64'(lat));
      check_eq({tag, "_err"}, 64'(bus.rsp_err), 64'(err));
      check_eq({tag, "_data"}, 64'(bus.rsp_data), 64'(exp_d));
    end
    @(negedge clk);
    check_eq({tag, "_strobe_drop"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  logic [DATA_W-1:0] vals [3];
  int acc_snap, wr_snap;

  initial begin
    vals[0] = 32'h12345678;
    vals[1] = 32'hAABBCCDD;
    vals[2] = 32'h11223344;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_data  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_mem_en_in_reset", 64'(mem_en), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 64'(bus.req_ready), 64'd1);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_full", 64'(full), 64'd0);
    check_eq("rst_mem_en", 64'(mem_en), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_sp", 64'(sp), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_data", 64'(bus.rsp_data), 64'd0);

    // Three pushes
    for (int i = 0; i < 3; i++) begin
      do_req(2'b00, vals[i], 2, 1'b0, 32'h0, "push3");
      check_eq("push3_waddr", 64'(last_waddr), 64'(i));
      check_eq("push3_wdata", 64'(last_wdata), 64'(vals[i]));
      check_eq("push3_wcnt", 64'(wr_cnt), 64'(i + 1));
    end
    check_eq("push3_sp", 64'(sp), 64'd3);
    check_eq("push3_empty", 64'(empty), 64'd0);

    // Three pops, reverse order
    for (int i = 2; i >= 0; i--) do_req(2'b01, 32'h0, 3, 1'b0, vals[i], "pop3");
    check_eq("pop3_sp", 64'(sp), 64'd0);
    check_eq("pop3_empty", 64'(empty), 64'd1);

    // Underflow on pop and peek
    acc_snap = acc_cnt;
    do_req(2'b01, 32'h0, 1, 1'b1, 32'h0, "pop_empty");
    do_req(2'b10, 32'h0, 1, 1'b1, 32'h0, "peek_empty");
    check_eq("underflow_no_access", 64'(acc_cnt), 64'(acc_snap));
    check_eq("underflow_sp", 64'(sp), 64'd0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) do_req(2'b00, 32'h100 + i, 2, 1'b0, 32'h0, "fill");
    check_eq("fill_sp", 64'(sp), 64'd16);
    check_eq("fill_full", 64'(full), 64'd1);
    check_eq("fill_last_waddr", 64'(last_waddr), 64'd15);
    wr_snap = wr_cnt;
    acc_snap = acc_cnt;
    do_req(2'b00, 32'h0BAD0BAD, 1, 1'b1, 32'h0, "push_full");
    check_eq("overflow_no_write", 64'(wr_cnt), 64'(wr_snap));
    check_eq("overflow_no_access", 64'(acc_cnt), 64'(acc_snap));
    check_eq("overflow_sp", 64'(sp), 64'd16);
    check_eq("overflow_full", 64'(full), 64'd1);
    do_req(2'b10, 32'h0, 3, 1'b0, 32'h10F, "peek_full");
    check_eq("peek_full_sp", 64'(sp), 64'd16);

    // Pop down to sp=5, then clear
    for (int i = 0; i < 11; i++) do_req(2'b01, 32'h0, 3, 1'b0, 32'h10F - i, "pop_down");
    check_eq("pop_down_sp", 64'(sp), 64'd5);
    acc_snap = acc_cnt;
    do_req(2'b11, 32'h0, 2, 1'b0, 32'h0, "clear");
    check_eq("clear_sp", 64'(sp), 64'd0);
    check_eq("clear_empty", 64'(empty), 64'd1);
    check_eq("clear_no_access", 64'(acc_cnt), 64'(acc_snap));
    do_req(2'b01, 32'h0, 1, 1'b1, 32'h0, "pop_after_clear");

    // Reset during RWAIT of a pop at sp=2
    do_req(2'b00, 32'hCAFE0001, 2, 1'b0, 32'h0, "rpush");
    do_req(2'b00, 32'hCAFE0002, 2, 1'b0, 32'h0, "rpush");
    do_req(2'b10, 32'h0, 3, 1'b0, 32'hCAFE0002, "rpeek");
    check_eq("rmid_sp_before", 64'(sp), 64'd2);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    @(posedge clk);
    @(negedge clk);                       // RD cycle
    bus.req_valid = 1'b0;
    check_eq("rmid_rd_mem_en", 64'(mem_en), 64'd1);
    check_eq("rmid_rd_addr", 64'(mem_addr), 64'd1);
    @(negedge clk);                       // RWAIT cycle
    check_eq("rmid_rwait_rsp", 64'(bus.rsp_valid), 64'd0);
    reset = 1'b1;
    acc_snap = acc_cnt;
    @(negedge clk);
    check_eq("rmid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rmid_ready", 64'(bus.req_ready), 64'd1);
    check_eq("rmid_sp", 64'(sp), 64'd0);
    check_eq("rmid_rsp_data", 64'(bus.rsp_data), 64'd0);
    check_eq("rmid_mem_en", 64'(mem_en), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rmid_after_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rmid_after_no_access", 64'(acc_cnt), 64'(acc_snap));
    check_eq("rmid_after_empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer for the processor's LIFO stack memory: owns the stack pointer and turns single push/pop/peek/clear requests from the control unit into timed accesses on a single-port synchronous RAM.
- Enforces full/empty rules and returns one response per request.
- Sits between the control unit (CALL/RET/PUSH/POP) and the stack RAM.

Parameters:
- DATA_W, 32, stack word width
- DEPTH, 16, number of entries (power of two)
- ADDR_W, 4, RAM address width, equal to log2(DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (IDLE only)
- req_op  in  2  00 push, 01 pop, 10 peek, 11 clear
- req_data  in  DATA_W  push data
- rsp_valid  out  1  one-cycle response strobe
- rsp_err  out  1  request rejected (overflow/underflow); qualified by rsp_valid
- rsp_data  out  DATA_W  popped/peeked word; 0 for push/clear/error
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read (mem_en=1, mem_we=0)
- sp  out  ADDR_W+1  entry count, 0..DEPTH
- full  out  1  sp==DEPTH
- empty  out  1  sp==0

Behaviour:
- Clock is clk; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: state=IDLE, sp=0, rsp_valid=0, rsp_err=0, rsp_data=0, latched op/data=0. Outputs after reset: req_ready=1, empty=1, full=0, mem_en=0, mem_we=0.
- full and empty decode combinationally from the sp register. mem_* and req_ready decode from state. mem_en and mem_we are forced to 0 while reset=1.
- Handshake:
  - A request is accepted when req_valid and req_ready are both 1.
  - On acceptance, req_op and req_data are latched; later changes are ignored.
  - req_ready=1 only in IDLE. No new request is accepted until the response has been issued.
- Decision at acceptance (IDLE):
  - push with !full -> WR; push with full -> ERR
  - pop or peek with !empty -> RD; pop or peek with empty -> ERR
  - clear -> CLR
- WR: mem_en=1, mem_we=1, mem_addr=sp[ADDR_W-1:0], mem_wdata=latched data; sp<=sp+1 -> RSP.
- RD: mem_en=1, mem_we=0, mem_addr=sp-1 -> RWAIT.
- RWAIT: rsp_data<=mem_rdata; if op=pop then sp<=sp-1 (peek leaves sp unchanged) -> RSP.
- CLR: sp<=0, rsp_data<=0 -> RSP. RAM contents are untouched.
- ERR: rsp_valid=1, rsp_err=1, rsp_data=0, sp unchanged, no RAM access -> IDLE.
- RSP: rsp_valid=1, rsp_err=0 -> IDLE.
- rsp_valid is a single-cycle strobe with no backpressure. rsp_data holds its last value until the next response.
- Latency, counted from the acceptance edge T:
  - push/clear: rsp_valid high in cycle T+2
  - pop/peek: rsp_valid high in cycle T+3
  - error: rsp_valid high in cycle T+1
- Boundaries:
  - sp never exceeds DEPTH and never goes below 0; there is no address wrap.
  - A push at full never writes the RAM.
  - A pop at empty never reads the RAM.
- Reset mid-operation: the in-flight request is dropped with no response and no further RAM access; the next cycle is IDLE with sp=0.

Test Plan:
- Reset, then push 0x12345678, 0xAABBCCDD, 0x11223344 -> writes to addr 0,1,2; rsp_valid at T+2 each with rsp_err=0; sp=3; empty=0.
- Pop three times -> rsp_data 0x11223344, 0xAABBCCDD, 0x12345678 at T+3 each; sp=0; empty=1.
- Pop and peek on empty -> rsp_valid with rsp_err=1 at T+1; rsp_data=0; mem_en never 1; sp=0.
- 16 pushes of 0x100+i, then a 17th push -> 17th gets rsp_err=1 and no RAM write; full=1. Peek then returns 0x10F with sp still 16.
- With sp=5, clear -> rsp_valid at T+2, rsp_err=0, sp=0, empty=1; a following pop returns rsp_err=1.
- Assert reset during RWAIT of a pop at sp=2 -> no rsp_valid; next cycle req_ready=1, sp=0, rsp_data=0.
